// File: rtl/core_div_pkg.sv
// Shared types and constants for the iterative integer divider.
package core_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;

  // Quotient returned for a zero divisor (all ones, both modes).
  localparam logic [DIV_W-1:0] DIV0_Q = '1;
  // Quotient returned for the signed most-negative / -1 case.
  localparam logic [DIV_W-1:0] OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/core_div_sign_fix.sv
// Turns the unsigned restoring result into the architectural result:
// applies the quotient/remainder signs and the div-by-zero / overflow overrides.
module core_div_sign_fix
  import core_div_pkg::*;
(
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] rem_i,
  input  logic             sign_q_i,
  input  logic             sign_r_i,
  input  logic             div0_i,
  input  logic             ovf_i,
  input  logic [DIV_W-1:0] z_raw_i,
  output logic [DIV_W-1:0] q_o,
  output logic [DIV_W-1:0] s_o
);

  // Overrides take priority; otherwise truncate toward zero and give the
  // remainder the sign of the dividend.
  always_comb begin
    q_o = sign_q_i ? -quo_i : quo_i;
    s_o = sign_r_i ? -rem_i : rem_i;
    if (div0_i) begin
      q_o = DIV0_Q;
      s_o = z_raw_i;
    end else if (ovf_i) begin
      q_o = OVF_Q;
      s_o = '0;
    end
  end

endmodule

// File: rtl/core_iter_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, one
// operation in flight, result held until consumed, abortable by flush.
//
// Handshakes: a request transfers on a cycle where div_valid_i and
// div_ready_o are both high; a result transfers on a cycle where res_valid_o
// and res_ready_i are both high. res_valid_o/q_o/s_o stay stable until the
// result transfers. flush_i blocks any transfer in its cycle and drops state.
module core_iter_divider
  import core_div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] s_o,
  output logic             busy_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q, z_raw_q;
  logic [WIDTH-1:0] q_q, s_q;
  logic             sign_q_q, sign_r_q, div0_q, ovf_q;

  logic             accept;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx, z_abs, d_abs;
  logic [WIDTH-1:0] fix_q, fix_s;

  assign div_ready_o = !flush_i &&
                       ((state_q == IDLE) || ((state_q == DONE) && res_ready_i));
  assign accept      = div_valid_i && div_ready_o;
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign q_o         = q_q;
  assign s_o         = s_q;

  // Operand magnitudes and one restoring step of the partial remainder.
  always_comb begin
    z_abs   = (signed_i && z_i[WIDTH-1]) ? -z_i : z_i;
    d_abs   = (signed_i && d_i[WIDTH-1]) ? -d_i : d_i;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    rem_ge  = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  core_div_sign_fix u_sign_fix (
    .quo_i    (quo_q),
    .rem_i    (rem_q),
    .sign_q_i (sign_q_q),
    .sign_r_i (sign_r_q),
    .div0_i   (div0_q),
    .ovf_i    (ovf_q),
    .z_raw_i  (z_raw_q),
    .q_o      (fix_q),
    .s_o      (fix_s)
  );

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (res_ready_i) state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture on accept, iteration in CALC, result registration in FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      z_raw_q  <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      q_q      <= '0;
      s_q      <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      dvd_q    <= z_abs;
      dvs_q    <= d_abs;
      rem_q    <= '0;
      quo_q    <= '0;
      z_raw_q  <= z_i;
      sign_q_q <= signed_i && (z_i[WIDTH-1] ^ d_i[WIDTH-1]);
      sign_r_q <= signed_i && z_i[WIDTH-1];
      div0_q   <= (d_i == '0);
      ovf_q    <= signed_i && (z_i == OVF_Q) && (d_i == '1);
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= rem_nx;
      quo_q <= {quo_q[WIDTH-2:0], rem_ge};
    end else if ((state_q == FIX) && !flush_i) begin
      q_q <= fix_q;
      s_q <= fix_s;
    end
  end

endmodule

// File: tb/tb_core_iter_divider.sv
// Bench for core_iter_divider: directed cases, random operands, backpressure,
// flush and reset-abort scenarios with an expected-result queue.
module tb_core_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic        signed_i;
  logic [31:0] z_i;
  logic [31:0] d_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] q_o;
  logic [31:0] s_o;
  logic        busy_o;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  core_iter_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .signed_i    (signed_i),
    .z_i         (z_i),
    .d_i         (d_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .q_o         (q_o),
    .s_o         (s_o),
    .busy_o      (busy_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: truncating division, remainder with dividend sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] z, input logic [31:0] d);
    logic [31:0] q, s;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      s = z;
    end else if (sgn && z == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      s = 32'd0;
    end else if (sgn) begin
      q = $signed(z) / $signed(d);
      s = $signed(z) % $signed(d);
    end else begin
      q = z / d;
      s = z % d;
    end
    return {q, s};
  endfunction

  // Drive one request at a negedge; returns just after the accepting edge.
  task automatic issue(input logic sgn, input logic [31:0] z, input logic [31:0] d,
                       input logic [31:0] eq, input logic [31:0] es);
    @(negedge clk);
    div_valid_i = 1'b1;
    signed_i    = sgn;
    z_i         = z;
    d_i         = d;
    check_eq("req_ready", {31'd0, div_ready_o}, 32'd1);
    exp_q.push_back({eq, es});
    @(posedge clk);
    #1;
    div_valid_i = 1'b0;
    signed_i    = $urandom_range(0, 1);
    z_i         = $urandom;
    d_i         = $urandom;
  endtask

  // Wait (bounded) for res_valid_o; checks 34-edge latency and ready/busy during the op.
  task automatic wait_result();
    int lat = 1;
    logic ready_seen = 1'b0;
    logic idle_seen  = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      if (res_valid_o) break;
      if (div_ready_o) ready_seen = 1'b1;
      if (!busy_o)     idle_seen  = 1'b1;
      @(posedge clk);
      lat++;
    end
    check_eq("latency", lat, 34);
    check_eq("ready_low_in_op", {31'd0, ready_seen}, 32'd0);
    check_eq("busy_in_op", {31'd0, idle_seen}, 32'd0);
  endtask

  // At the current negedge compare against the queue head and consume the result.
  task automatic consume();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_eq("q", q_o, e[63:32]);
    check_eq("s", s_o, e[31:0]);
    res_ready_i = 1'b1;
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    @(negedge clk);
    check_eq("valid_drop", {31'd0, res_valid_o}, 32'd0);
    check_eq("q_retain", q_o, e[63:32]);
    check_eq("s_retain", s_o, e[31:0]);
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] z, input logic [31:0] d,
                        input logic [31:0] eq, input logic [31:0] es);
    issue(sgn, z, d, eq, es);
    wait_result();
    consume();
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] rz, rd;
    logic        rs;

    rst_n       = 1'b0;
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    res_ready_i = 1'b0;
    signed_i    = 1'b0;
    z_i         = '0;
    d_i         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, res_valid_o}, 32'd0);
    check_eq("rst_q", q_o, 32'd0);
    check_eq("rst_s", s_o, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, div_ready_o}, 32'd1);

    // Directed arithmetic cases.
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
    run_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Random operands against the model.
    for (int i = 0; i < 8; i++) begin
      rs = $urandom_range(0, 1);
      rz = $urandom;
      rd = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 7) rd = -32'd3;
      e  = model(rs, rz, rd);
      run_op(rs, rz, rd, e[63:32], e[31:0]);
    end

    // Backpressure, then back-to-back accept on the consuming cycle.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, res_valid_o}, 32'd1);
      check_eq("bp_q", q_o, 32'd14);
      check_eq("bp_s", s_o, 32'd2);
      check_eq("bp_ready", {31'd0, div_ready_o}, 32'd0);
      @(negedge clk);
    end
    res_ready_i = 1'b1;
    div_valid_i = 1'b1;
    signed_i    = 1'b0;
    z_i         = 32'd9;
    d_i         = 32'd3;
    #1;
    check_eq("b2b_ready", {31'd0, div_ready_o}, 32'd1);
    e = exp_q.pop_front();
    check_eq("bp_pop_q", q_o, e[63:32]);
    check_eq("bp_pop_s", s_o, e[31:0]);
    exp_q.push_back({32'd3, 32'd0});
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    div_valid_i = 1'b0;
    z_i         = $urandom;
    d_i         = $urandom;
    wait_result();
    consume();

    // Flush mid-calculation.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    check_eq("flush_no_ready", {31'd0, div_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    void'(exp_q.pop_back());
    begin
      logic v_seen = 1'b0;
      @(negedge clk);
      check_eq("flush_ready", {31'd0, div_ready_o}, 32'd1);
      check_eq("flush_busy", {31'd0, busy_o}, 32'd0);
      for (int i = 0; i < 40; i++) begin
        if (res_valid_o) v_seen = 1'b1;
        @(negedge clk);
      end
      check_eq("flush_no_result", {31'd0, v_seen}, 32'd0);
    end
    run_op(1'b0, 32'd10, 32'd3, 32'd3, 32'd1);

    // Flush in DONE beats simultaneous res_ready_i and div_valid_i.
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    wait_result();
    flush_i     = 1'b1;
    res_ready_i = 1'b1;
    div_valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    res_ready_i = 1'b0;
    div_valid_i = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    check_eq("flush_done_valid", {31'd0, res_valid_o}, 32'd0);
    check_eq("flush_done_busy", {31'd0, busy_o}, 32'd0);

    // Reset mid-operation.
    issue(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, res_valid_o}, 32'd0);
    check_eq("mid_rst_q", q_o, 32'd0);
    check_eq("mid_rst_s", s_o, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_eq("mid_rst_ready", {31'd0, div_ready_o}, 32'd1);
    run_op(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
